// File: rtl/cmp_serial_unit.sv
// Digit-serial magnitude compare (SLT/SLTU/SGE/SGEU). Examines DIGIT bits per
// cycle, MSB first, and returns a mask or a 0/1 value behind valid/ready.
module cmp_serial_unit #(
    parameter int WIDTH    = 32,
    parameter int DIGIT    = 4,
    parameter bit MASK_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] TRUE_VAL = MASK_OUT ? {WIDTH{1'b1}} : WIDTH'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             ge_q, ge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [DIGIT-1:0] a_dig, b_dig;
    logic             lt_scan, gt_scan;

    // Operands shift left each RUN cycle, so the digit under test is always the top slice.
    assign a_dig = a_q[WIDTH-1 -: DIGIT];
    assign b_dig = b_q[WIDTH-1 -: DIGIT];

    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
        lt_scan = lt_q;
        gt_scan = gt_q;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            if (!lt_scan && !gt_scan && (a_dig[i] != b_dig[i])) begin
                lt_scan = b_dig[i];
                gt_scan = a_dig[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ge_d     = ge_q;
        cnt_d    = cnt_q;
        lt_d     = lt_q;
        gt_d     = gt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    // Flipping the sign bits turns a two's-complement compare into an unsigned one.
                    a_d     = op_i[0] ? a_i : (a_i ^ SIGN_BIT);
                    b_d     = op_i[0] ? b_i : (b_i ^ SIGN_BIT);
                    ge_d    = op_i[1];
                    cnt_d   = '0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                lt_d  = lt_scan;
                gt_d  = gt_scan;
                a_d   = a_q << DIGIT;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    result_d = (ge_q ^ lt_scan) ? TRUE_VAL : '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            ge_q     <= 1'b0;
            cnt_q    <= '0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ge_q     <= ge_d;
            cnt_q    <= cnt_d;
            lt_q     <= lt_d;
            gt_q     <= gt_d;
            result_q <= result_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;

endmodule

// File: tb/tb_cmp_serial_unit.sv
// Directed bench for cmp_serial_unit: a 32/4 mask instance and a 16/8 0/1 instance,
// each shadowed by a transaction-level model checked every cycle.
module tb_cmp_serial_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, flush, out_ready, in_ready, out_valid, busy;
    logic [31:0] a, b, result;
    logic [1:0]  op;

    logic        s_in_valid, s_flush, s_out_ready, s_in_ready, s_out_valid, s_busy;
    logic [15:0] s_a, s_b, s_result;
    logic [1:0]  s_op;

    int tests = 0;
    int fails = 0;

    cmp_serial_unit #(.WIDTH(32), .DIGIT(4), .MASK_OUT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .op_i(op), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .result_o(result), .busy_o(busy)
    );

    cmp_serial_unit #(.WIDTH(16), .DIGIT(8), .MASK_OUT(1'b0)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .a_i(s_a), .b_i(s_b), .op_i(s_op), .flush_i(s_flush), .out_valid_o(s_out_valid),
        .out_ready_i(s_out_ready), .result_o(s_result), .busy_o(s_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare result from plain signed/unsigned arithmetic on sign- or zero-extended operands.
    function automatic logic [31:0] ref_cmp(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] o, input int w, input bit mask);
        logic signed [32:0] sx, sy;
        logic lt, truth;
        if (w == 16) begin
            sx = o[0] ? {17'b0, x[15:0]} : {{17{x[15]}}, x[15:0]};
            sy = o[0] ? {17'b0, y[15:0]} : {{17{y[15]}}, y[15:0]};
        end else begin
            sx = o[0] ? {1'b0, x} : {x[31], x};
            sy = o[0] ? {1'b0, y} : {y[31], y};
        end
        lt    = (sx < sy);
        truth = o[1] ? !lt : lt;
        if (!truth) return 32'h0;
        if (!mask) return 32'h1;
        return (w == 16) ? 32'h0000FFFF : 32'hFFFFFFFF;
    endfunction

    // Transaction-level models: accept when idle, result after N edges, release on out_ready.
    logic        m_busy, m_valid, m16_busy, m16_valid;
    logic [31:0] m_res, m_pend, m16_res, m16_pend;
    int          m_left, m16_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_res <= '0; m_pend <= '0; m_left <= 0;
        end else if (flush) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_res <= '0;
        end else if (!m_busy && in_valid) begin
            m_busy <= 1'b1; m_left <= 8; m_pend <= ref_cmp(a, b, op, 32, 1'b1);
        end else if (m_busy && !m_valid) begin
            if (m_left == 1) begin m_valid <= 1'b1; m_res <= m_pend; end
            m_left <= m_left - 1;
        end else if (m_valid && out_ready) begin
            m_busy <= 1'b0; m_valid <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m16_busy <= 1'b0; m16_valid <= 1'b0; m16_res <= '0; m16_pend <= '0; m16_left <= 0;
        end else if (s_flush) begin
            m16_busy <= 1'b0; m16_valid <= 1'b0; m16_res <= '0;
        end else if (!m16_busy && s_in_valid) begin
            m16_busy <= 1'b1; m16_left <= 2; m16_pend <= ref_cmp({16'b0, s_a}, {16'b0, s_b}, s_op, 16, 1'b0);
        end else if (m16_busy && !m16_valid) begin
            if (m16_left == 1) begin m16_valid <= 1'b1; m16_res <= m16_pend; end
            m16_left <= m16_left - 1;
        end else if (m16_valid && s_out_ready) begin
            m16_busy <= 1'b0; m16_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m32_in_ready",  32'(in_ready),    32'(!m_busy));
            check("m32_busy",      32'(busy),        32'(m_busy));
            check("m32_out_valid", 32'(out_valid),   32'(m_valid));
            check("m32_result",    result,           m_res);
            check("m16_in_ready",  32'(s_in_ready),  32'(!m16_busy));
            check("m16_busy",      32'(s_busy),      32'(m16_busy));
            check("m16_out_valid", 32'(s_out_valid), 32'(m16_valid));
            check("m16_result",    32'(s_result),    m16_res);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge, operands scrambled.
    task automatic req(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o);
        int k = 0;
        while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
        if (k == 50) check("req_timeout_in_ready", 32'(in_ready), 32'h1);
        a = x; b = y; op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic txn(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o,
                       input logic [31:0] exp, input string nm);
        int lat;
        req(x, y, o);
        wait_valid(lat);
        check({nm, "_latency"}, lat, 32'd8);
        check(nm, result, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 2'b00;
        s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_result",    result,         32'h0);
        check("reset_busy",      32'(busy),      32'h0);
        check("reset_in_ready",  32'(in_ready),  32'h1);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        txn(32'hFFFFFFFF, 32'h00000001, 2'b00, 32'hFFFFFFFF, "t1_slt_neg");
        txn(32'hFFFFFFFF, 32'h00000001, 2'b01, 32'h00000000, "t1_sltu_big");
        txn(32'h12345678, 32'h12345678, 2'b00, 32'h00000000, "t2_lt_equal");
        txn(32'h12345678, 32'h12345678, 2'b10, 32'hFFFFFFFF, "t2_ge_equal");
        txn(32'h12345670, 32'h12345671, 2'b01, 32'hFFFFFFFF, "t2_last_digit");
        txn(32'h80000000, 32'h00000000, 2'b11, 32'hFFFFFFFF, "dv_geu_msb");
        txn(32'h80000000, 32'h00000000, 2'b10, 32'h00000000, "dv_ge_min");
        txn(32'h7FFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000000, "dv_lt_max");

        // Backpressure
        out_ready = 1'b0;
        req(32'h9, 32'h3, 2'b11);
        wait_valid(lat);
        check("t3_latency", lat, 32'd8);
        repeat (5) begin
            @(posedge clk); #1;
            check("t3_hold_valid",    32'(out_valid), 32'h1);
            check("t3_hold_result",   result,         32'hFFFFFFFF);
            check("t3_hold_busy",     32'(busy),      32'h1);
            check("t3_hold_in_ready", 32'(in_ready),  32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_release_valid",    32'(out_valid), 32'h0);
        check("t3_release_in_ready", 32'(in_ready),  32'h1);

        // Flush on the third RUN cycle with a competing request
        req(32'h00001234, 32'h00001233, 2'b01);
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1; a = 32'h1; b = 32'h2; op = 2'b01;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("t4_flush_busy",     32'(busy),      32'h0);
        check("t4_flush_valid",    32'(out_valid), 32'h0);
        check("t4_flush_in_ready", 32'(in_ready),  32'h1);
        txn(32'h80000000, 32'h7FFFFFFF, 2'b00, 32'hFFFFFFFF, "t4_after_flush");

        // Reset on the fifth RUN cycle
        req(32'h1, 32'h2, 2'b01);
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid",  32'(out_valid), 32'h0);
        check("t5_rst_result", result,         32'h0);
        check("t5_rst_busy",   32'(busy),      32'h0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        txn(32'h5, 32'h7, 2'b01, 32'hFFFFFFFF, "t5_after_reset");

        // 16-bit, 8-bit digit, 0/1 result
        s_a = 16'h7FFF; s_b = 16'h8000; s_op = 2'b10; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("t6_ge_latency", lat, 32'd2);
        check("t6_ge_signed",  32'(s_result), 32'h00000001);
        @(posedge clk); #1;
        s_op = 2'b11; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("t6_geu_latency", lat, 32'd2);
        check("t6_geu_unsigned", 32'(s_result), 32'h00000000);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
